// File: rtl/rf_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the 32x32 register file and its users.
//   XLEN       : architectural data width
//   AW         : register address width
//   NUM_REGS   : number of architectural registers
//   reg_addr_t : register index
//   xlen_t     : register value
//   wb_entry_t : one pending writeback (destination + value)
//   cnt_w()    : width of an occupancy counter for a given depth
// ----------------------------------------------------------------------------
package rf_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned AW       = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xlen_t;

    typedef struct packed {
        reg_addr_t addr;
        xlen_t     data;
    } wb_entry_t;

    // Occupancy 0..depth inclusive needs one more state than a pointer.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// ----------------------------------------------------------------------------
// rf_wb_fifo
// Circular buffer of pending register writebacks. Storage is not reset; only
// the pointers and the occupancy count are. Every entry is exposed together
// with a valid bit so the parent can search it for forwarding.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_push        : enqueue i_push_addr/i_push_data at the tail
//   i_pop         : dequeue the head (never asserted when empty)
//   o_full        : count == DEPTH
//   o_empty       : count == 0
//   o_count       : current occupancy
//   o_rd_ptr      : physical index of the oldest entry
//   o_valid       : per-physical-entry valid bit
//   o_ent_addr    : per-entry destination register
//   o_ent_data    : per-entry value
//   o_head_addr   : destination of the oldest entry
//   o_head_data   : value of the oldest entry
// ----------------------------------------------------------------------------
module rf_wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = rf_pkg::XLEN,
    parameter int unsigned AW    = rf_pkg::AW
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_push,
    input  logic [AW-1:0]                   i_push_addr,
    input  logic [XLEN-1:0]                 i_push_data,
    input  logic                            i_pop,
    output logic                            o_full,
    output logic                            o_empty,
    output logic [$clog2(DEPTH+1)-1:0]      o_count,
    output logic [$clog2(DEPTH)-1:0]        o_rd_ptr,
    output logic [DEPTH-1:0]                o_valid,
    output logic [AW-1:0]                   o_ent_addr [DEPTH],
    output logic [XLEN-1:0]                 o_ent_data [DEPTH],
    output logic [AW-1:0]                   o_head_addr,
    output logic [XLEN-1:0]                 o_head_data
);

    import rf_pkg::*;

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_d;

    logic [AW-1:0]   r_addr_mem [DEPTH];
    logic [XLEN-1:0] r_data_mem [DEPTH];

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        w_count_d = r_count;
        unique case ({i_push, i_pop})
            2'b10:   w_count_d = r_count + CW'(1);
            2'b01:   w_count_d = r_count - CW'(1);
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_d;
        end
    end

    // Payload storage has no reset; valid bits alone qualify the contents.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr_mem[r_wr_ptr] <= i_push_addr;
            r_data_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // An entry is live when its distance from the head is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        logic [PW-1:0] w_off;
        assign w_off          = PW'(gi) - r_rd_ptr;
        assign o_valid[gi]    = (CW'(w_off) < r_count);
        assign o_ent_addr[gi] = r_addr_mem[gi];
        assign o_ent_data[gi] = r_data_mem[gi];
    end

    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_rd_ptr    = r_rd_ptr;
    assign o_head_addr = r_addr_mem[r_rd_ptr];
    assign o_head_data = r_data_mem[r_rd_ptr];

endmodule

// File: rtl/rf_wb_sequencer.sv
// ----------------------------------------------------------------------------
// rf_wb_sequencer
// Write-side scheduler for the 32x32 register file. Writeback results are
// queued and drained through the single RF write port only in cycles where
// decode is not reading, because the RF refreshes rD1/rD2 only while we=0.
// Decode reads see queued-but-unwritten results through a bypass search.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   wb_valid/wb_ready   : writeback handshake (wb_ready = FIFO not full)
//   wb_addr, wb_data    : writeback destination and value (x0 dropped)
//   rd_req/rd_ready     : decode read request / grant
//   rs1, rs2            : decode source registers
//   rs1_data, rs2_data  : operands after bypass (meaningful when rd_ready)
//   rf_rR1, rf_rR2      : RF read addresses (pass-through of rs1/rs2)
//   rf_rD1, rf_rD2      : RF read data
//   rf_we, rf_wR, rf_wD : RF write port, driven from the FIFO head
//   pending             : FIFO occupancy
// ----------------------------------------------------------------------------
module rf_wb_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = rf_pkg::XLEN,
    parameter int unsigned AW    = rf_pkg::AW
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wb_valid,
    output logic                        wb_ready,
    input  logic [AW-1:0]               wb_addr,
    input  logic [XLEN-1:0]             wb_data,
    input  logic                        rd_req,
    output logic                        rd_ready,
    input  logic [AW-1:0]               rs1,
    input  logic [AW-1:0]               rs2,
    output logic [XLEN-1:0]             rs1_data,
    output logic [XLEN-1:0]             rs2_data,
    output logic [AW-1:0]               rf_rR1,
    output logic [AW-1:0]               rf_rR2,
    input  logic [XLEN-1:0]             rf_rD1,
    input  logic [XLEN-1:0]             rf_rD2,
    output logic                        rf_we,
    output logic [AW-1:0]               rf_wR,
    output logic [XLEN-1:0]             rf_wD,
    output logic [$clog2(DEPTH+1)-1:0]  pending
);

    import rf_pkg::*;

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [PW-1:0]   w_rd_ptr;
    logic [DEPTH-1:0] w_valid;
    logic [AW-1:0]   w_ent_addr [DEPTH];
    logic [XLEN-1:0] w_ent_data [DEPTH];
    logic [AW-1:0]   w_head_addr;
    logic [XLEN-1:0] w_head_data;
    logic [PW-1:0]   w_idx;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    rf_wb_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .AW    (AW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_addr (wb_addr),
        .i_push_data (wb_data),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_rd_ptr    (w_rd_ptr),
        .o_valid     (w_valid),
        .o_ent_addr  (w_ent_addr),
        .o_ent_data  (w_ent_data),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data)
    );

    // wb_ready depends on registered occupancy only, never on rd_req.
    assign wb_ready = !w_full;
    // x0 writes complete the handshake but are never queued.
    assign w_push   = wb_valid && !w_full && (wb_addr != '0);

    // Reads win the RF unless the FIFO is full; then one drain is forced.
    assign w_pop    = !w_empty && (!rd_req || w_full);
    assign rd_ready = rd_req && !w_pop;

    assign rf_we    = w_pop;
    assign rf_wR    = w_head_addr;
    assign rf_wD    = w_head_data;
    assign rf_rR1   = rs1;
    assign rf_rR2   = rs2;
    assign pending  = w_count;

    // Walk from oldest to youngest so the last hit is the newest value.
    // Only registered FIFO state is searched: a same-cycle push is not seen.
    always_comb begin
        w_rs1_data = rf_rD1;
        w_rs2_data = rf_rD2;
        w_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = w_rd_ptr + PW'(k);
            if (w_valid[w_idx] && (w_ent_addr[w_idx] == rs1)) begin
                w_rs1_data = w_ent_data[w_idx];
            end
            if (w_valid[w_idx] && (w_ent_addr[w_idx] == rs2)) begin
                w_rs2_data = w_ent_data[w_idx];
            end
        end
        if (rs1 == '0) begin
            w_rs1_data = '0;
        end
        if (rs2 == '0) begin
            w_rs2_data = '0;
        end
    end

    assign rs1_data = w_rs1_data;
    assign rs2_data = w_rs2_data;

endmodule

// File: tb/tb_rf_wb_sequencer.sv
// ----------------------------------------------------------------------------
// tb_rf_wb_sequencer
// Directed stimulus with a scoreboard. Expected RF writes and expected read
// operands are queued as stimulus is issued; a monitor pops and compares on
// every rf_we and every rd_ready. A behavioural RF sits on the RF ports.
// ----------------------------------------------------------------------------
module tb_rf_wb_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic            clk;
    logic            rst_n;
    logic            wb_valid;
    logic            wb_ready;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            rd_req;
    logic            rd_ready;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [AW-1:0]   rf_rR1;
    logic [AW-1:0]   rf_rR2;
    logic [XLEN-1:0] rf_rD1;
    logic [XLEN-1:0] rf_rD2;
    logic            rf_we;
    logic [AW-1:0]   rf_wR;
    logic [XLEN-1:0] rf_wD;
    logic [CW-1:0]   pending;

    int n_checks = 0;
    int n_pass   = 0;

    logic [AW+XLEN-1:0] exp_wr [$];
    logic [2*XLEN-1:0]  exp_rd [$];

    logic [XLEN-1:0] rf_mem [32];

    rf_wb_sequencer #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .AW    (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rd_req   (rd_req),
        .rd_ready (rd_ready),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rf_rR1   (rf_rR1),
        .rf_rR2   (rf_rR2),
        .rf_rD1   (rf_rD1),
        .rf_rD2   (rf_rD2),
        .rf_we    (rf_we),
        .rf_wR    (rf_wR),
        .rf_wD    (rf_wD),
        .pending  (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural register file on the DUT's RF ports.
    always @(posedge clk) begin
        if (rf_we === 1'b1) rf_mem[rf_wR] <= rf_wD;
    end
    assign rf_rD1 = rf_mem[rf_rR1];
    assign rf_rD2 = rf_mem[rf_rR2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: compare every RF write and every read grant against the queues.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rf_we === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    $display("FAIL rf write: got wR=%0d wD=%h, expected no write", rf_wR, rf_wD);
                end else begin
                    check("rf write {wR,wD}", 64'({rf_wR, rf_wD}), 64'(exp_wr.pop_front()));
                end
            end
            if (rd_ready === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    n_checks++;
                    $display("FAIL read grant: got rs1=%h rs2=%h, expected no grant",
                             rs1_data, rs2_data);
                end else begin
                    check("read {rs1_data,rs2_data}", {rs1_data, rs2_data}, exp_rd.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                         input logic rq, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        @(posedge clk);
        #1;
        wb_valid = v;
        wb_addr  = wa;
        wb_data  = wd;
        rd_req   = rq;
        rs1      = a1;
        rs2      = a2;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 12 && pending != '0; i++) idle();
        check("drain completes", 64'(pending), 64'(0));
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        exp_wr.push_back({a, d});
    endtask

    task automatic push_rd(input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2);
        exp_rd.push_back({d1, d2});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA000_0000 + i;
        rf_mem[0] = 32'h5555_5555;
        rst_n    = 1'b1;
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        rd_req   = 1'b0;
        rs1      = '0;
        rs2      = '0;

        // Asynchronous reset, asserted and sampled before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("reset rf_we", 64'(rf_we), 64'(0));
        check("reset wb_ready", 64'(wb_ready), 64'(1));
        check("reset pending", 64'(pending), 64'(0));
        check("reset rd_ready", 64'(rd_ready), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single writeback drains the following cycle.
        push_wr(5'd5, 32'hDEAD_BEEF);
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
        check("t1 wb_ready", 64'(wb_ready), 64'(1));
        check("t1 rf_we idle", 64'(rf_we), 64'(0));
        idle();
        check("t1 rf_we drain", 64'(rf_we), 64'(1));
        check("t1 rf_wR", 64'(rf_wR), 64'(5));
        check("t1 pending 1", 64'(pending), 64'(1));
        idle();
        check("t1 pending 0", 64'(pending), 64'(0));
        push_rd(32'hDEAD_BEEF, 32'hA000_0006);
        drive(1'b0, '0, '0, 1'b1, 5'd5, 5'd6);
        check("t1 rd_ready", 64'(rd_ready), 64'(1));

        // Youngest of two pending writes to r3 is forwarded.
        push_rd(32'hA000_0003, 32'h0);
        push_wr(5'd3, 32'h11);
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 5'd0);
        check("t2 no drain c1", 64'(rf_we), 64'(0));
        push_rd(32'h11, 32'h0);
        push_wr(5'd3, 32'h22);
        drive(1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 5'd0);
        check("t2 no drain c2", 64'(rf_we), 64'(0));
        push_rd(32'h22, 32'h0);
        drive(1'b0, '0, '0, 1'b1, 5'd3, 5'd0);
        check("t2 pending 2", 64'(pending), 64'(2));
        check("t2 no drain c3", 64'(rf_we), 64'(0));
        idle();
        check("t2 drain 1", 64'(rf_we), 64'(1));
        idle();
        check("t2 drain 2 pending", 64'(pending), 64'(1));
        idle();
        check("t2 pending 0", 64'(pending), 64'(0));
        push_rd(32'h22, 32'h0);
        drive(1'b0, '0, '0, 1'b1, 5'd3, 5'd0);

        // Full FIFO forces one drain cycle while decode stalls.
        push_rd(32'hA000_0001, 32'hA000_0004);
        push_wr(5'd1, 32'h1);
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd1, 5'd4);
        push_rd(32'h1, 32'hA000_0004);
        push_wr(5'd2, 32'h2);
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd1, 5'd4);
        push_rd(32'h1, 32'hA000_0004);
        push_wr(5'd3, 32'h3);
        drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd1, 5'd4);
        push_rd(32'h1, 32'hA000_0004);
        push_wr(5'd4, 32'h4);
        drive(1'b1, 5'd4, 32'h4, 1'b1, 5'd1, 5'd4);
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd1, 5'd4);
        check("t3 pending full", 64'(pending), 64'(4));
        check("t3 wb_ready full", 64'(wb_ready), 64'(0));
        check("t3 forced rf_we", 64'(rf_we), 64'(1));
        check("t3 forced rf_wR", 64'(rf_wR), 64'(1));
        check("t3 stalled rd_ready", 64'(rd_ready), 64'(0));
        push_rd(32'h1, 32'h4);
        push_wr(5'd9, 32'h99);
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd1, 5'd4);
        check("t3 rd_ready resumes", 64'(rd_ready), 64'(1));
        check("t3 wb_ready resumes", 64'(wb_ready), 64'(1));
        check("t3 pending 3", 64'(pending), 64'(3));
        wait_drain();

        // Push and pop together, with the tail wrapping from index 3 to 0.
        for (int i = 0; i < 3; i++) begin
            push_rd(32'h0, 32'h0);
            push_wr(AW'(10 + i), XLEN'(32'hA + i));
            drive(1'b1, AW'(10 + i), XLEN'(32'hA + i), 1'b1, 5'd0, 5'd0);
        end
        idle();
        check("t4 drain before pairs", 64'(rf_we), 64'(1));
        check("t4 pending 3", 64'(pending), 64'(3));
        push_wr(5'd7, 32'h77);
        drive(1'b1, 5'd7, 32'h77, 1'b0, '0, '0);
        check("t4 pair1 pending", 64'(pending), 64'(2));
        check("t4 pair1 rf_we", 64'(rf_we), 64'(1));
        push_wr(5'd8, 32'h88);
        drive(1'b1, 5'd8, 32'h88, 1'b0, '0, '0);
        check("t4 pair2 pending", 64'(pending), 64'(2));
        push_rd(32'h88, 32'h77);
        drive(1'b0, '0, '0, 1'b1, 5'd8, 5'd7);
        check("t4 pending after pairs", 64'(pending), 64'(2));
        check("t4 rd_ready", 64'(rd_ready), 64'(1));
        wait_drain();

        // x0 writeback is accepted and dropped; x0 reads return zero.
        drive(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0);
        check("t5 wb_ready", 64'(wb_ready), 64'(1));
        check("t5 rf_we", 64'(rf_we), 64'(0));
        idle();
        check("t5 pending", 64'(pending), 64'(0));
        check("t5 no write", 64'(rf_we), 64'(0));
        push_rd(32'h0, 32'h0);
        drive(1'b0, '0, '0, 1'b1, 5'd0, 5'd0);
        check("t5 rd_ready", 64'(rd_ready), 64'(1));

        // Reset with three writes pending discards them.
        push_rd(32'hA000_0014, 32'hA000_0015);
        push_wr(5'd20, 32'h200);
        drive(1'b1, 5'd20, 32'h200, 1'b1, 5'd20, 5'd21);
        push_rd(32'h200, 32'hA000_0015);
        push_wr(5'd21, 32'h210);
        drive(1'b1, 5'd21, 32'h210, 1'b1, 5'd20, 5'd21);
        push_rd(32'h200, 32'h210);
        push_wr(5'd22, 32'h220);
        drive(1'b1, 5'd22, 32'h220, 1'b1, 5'd20, 5'd21);
        check("t6 pending 2", 64'(pending), 64'(2));
        exp_wr.delete();
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        rd_req   = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("t6 reset pending", 64'(pending), 64'(0));
        check("t6 reset rf_we", 64'(rf_we), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            check("t6 no write after reset", 64'(rf_we), 64'(0));
        end
        push_rd(32'hA000_0014, 32'hA000_0016);
        drive(1'b0, '0, '0, 1'b1, 5'd20, 5'd22);
        check("t6 rd_ready", 64'(rd_ready), 64'(1));
        idle();

        check("write queue drained", 64'(exp_wr.size()), 64'(0));
        check("read queue drained", 64'(exp_rd.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_sequencer.md
Name: rf_wb_sequencer

Overview:
- Sits on the write side of the 32x32 register file, between the writeback stage and the RF write and read ports.
- Buffers writeback results in a small FIFO and drains them to the RF's single write port.
- Schedules the RF so that `we` is low in every cycle a decode read is granted. The RF only refreshes `rD1`/`rD2` while `we` is 0.
- Forwards pending (not yet written) results to decode reads so that reads always see the architecturally newest value.

Parameters:
- DEPTH, 4: writeback FIFO entries. Power of two, at least 2.
- XLEN, 32: data width.
- AW, 5: register address width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- wb_valid  in  1  writeback result offered.
- wb_ready  out  1  writeback result accepted this cycle when wb_valid=1.
- wb_addr  in  AW  destination register.
- wb_data  in  XLEN  result value.
- rd_req  in  1  decode requests operand read this cycle.
- rd_ready  out  1  read granted; rs1_data and rs2_data are valid this cycle.
- rs1  in  AW  source address 1.
- rs2  in  AW  source address 2.
- rs1_data  out  XLEN  operand 1 after bypass.
- rs2_data  out  XLEN  operand 2 after bypass.
- rf_rR1  out  AW  to RF rR1; equals rs1.
- rf_rR2  out  AW  to RF rR2; equals rs2.
- rf_rD1  in  XLEN  from RF rD1.
- rf_rD2  in  XLEN  from RF rD2.
- rf_we  out  1  to RF we.
- rf_wR  out  AW  to RF wR; FIFO head address.
- rf_wD  out  XLEN  to RF wD; FIFO head data.
- pending  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0, async):
  - count=0, rd_ptr=0, wr_ptr=0.
  - Resulting outputs: rf_we=0, rd_ready=0, wb_ready=1, pending=0.
  - FIFO data storage is not reset.
  - Reset mid-operation discards all pending writes; the RF keeps whatever it already holds.
- State: circular FIFO with rd_ptr, wr_ptr and count. full = (count==DEPTH); empty = (count==0).
- Push:
  - wb_ready = !full. This is registered-state only, with no combinational path from rd_req.
  - On wb_valid && wb_ready with wb_addr != 0: entry written at wr_ptr, wr_ptr wraps modulo DEPTH.
  - wb_addr == 0: handshake completes but nothing is enqueued (x0 writes dropped).
- Drain (combinational decision):
  - rf_we = !empty && (!rd_req || full).
  - When rf_we=1: the head is written to the RF at posedge, rd_ptr wraps modulo DEPTH.
- Read grant:
  - rd_ready = rd_req && !rf_we.
  - Reads take priority unless the FIFO is full. When full, one drain cycle is forced and decode stalls that cycle.
  - Empty FIFO and rd_req: granted the same cycle, 0-cycle latency.
- Count update:
  - push only: +1. Pop only: -1.
  - Push and pop in the same cycle: count unchanged, pointers both advance.
  - A push is never accepted when full, so no overflow. Pop is never attempted when empty.
- Bypass, per operand, combinational:
  - rsX==0 -> 0.
  - Else, if any valid FIFO entry matches rsX, return the youngest matching entry, scanning from wr_ptr-1 back to rd_ptr.
  - Else return rf_rDX.
  - A result pushed in the same cycle is NOT forwarded; it becomes visible next cycle.
- rs1_data and rs2_data are don't-care when rd_ready=0.
- An RF write and a decode read never coincide, so RF read data is never stale.

Decomposition:
- Shared package rf_pkg:
  - Constants: XLEN=32, AW=5, NUM_REGS=32.
  - Typedefs: reg_addr_t (logic [AW-1:0]), xlen_t (logic [XLEN-1:0]), wb_entry_t (struct: addr, data).
  - Used by this block and by any future RF users.
- One sub-module: rf_wb_fifo.
  - Contents: storage, pointers, count, and a per-entry valid vector exposed for the bypass scan.
  - The top level keeps the grant/drain arbitration and the bypass muxes.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> rf_we=0, wb_ready=1, pending=0 immediately (async). Writeback r5=0xDEAD_BEEF with rd_req=0 -> rf_we=1, rf_wR=5, rf_wD=0xDEADBEEF on the following cycle, pending back to 0.
- Bypass youngest: push r3=0x11 then r3=0x22 while rd_req=1 continuously, rs1=3 -> rd_ready=1 and rs1_data=0x22 while both are pending; RF is unchanged until rd_req drops, then two drain cycles write 0x11 then 0x22.
- Full-forced drain: rd_req=1 held, push 4 writes (r1..r4=1..4) -> count=4, wb_ready=0. Next cycle rf_we=1, rf_wR=1, rd_ready=0. The following cycle rd_ready=1 and wb_ready=1.
- Simultaneous push/pop: count=2, rd_req=0, push r7=0x77 -> pending stays 2, pointers wrap correctly across index DEPTH-1 -> 0.
- x0 handling: push r0=0xFFFF -> wb_ready=1, pending unchanged, rf_we never asserted for wR=0. Read rs1=0, rs2=0 -> both return 0 regardless of RF contents.
- Reset mid-drain: 3 entries pending, assert rst_n=0 -> pending=0 and no further rf_we. Read of a discarded register returns the old RF value.
